uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one 8-bit stream sink (the uart_tx byte stream) between N byte-stream requesters.
//   Round-robin arbitration with line locking: a granted source keeps the link until it sends TERM,
//   hits MAX_BURST bytes, or goes silent for TIMEOUT cycles, so text lines never interleave.
//   Sits between producer blocks (e.g. inc, status reporters) and uart_tx in the top-level.
// PARAMETERS
//   N          2      number of requesters, 2..8
//   TERM       8'h0A  line terminator byte; a transfer of TERM ends the lock
//   MAX_BURST  64     max bytes per grant, >=1; lock ends on the MAX_BURST-th transfer
//   TIMEOUT    1024   consecutive cycles with in_valid[grant]=0 before forced release, >=1
// PORTS
//   clk           in   1     system clock
//   rst           in   1     synchronous reset, active high
//   in_valid      in   N     per-requester byte valid
//   in_data       in   8*N   per-requester byte; requester i at [8*i+7:8*i]
//   in_ready      out  N     per-requester ready
//   out_valid     out  1     byte valid towards uart_tx
//   out_data      out  8     byte towards uart_tx
//   out_ready     in   1     uart_tx ready
//   grant_valid   out  1     1 while a requester holds the lock
//   grant_idx     out  $clog2(N)  index of the current/last holder
// BEHAVIOUR
//   - Transfer on any port = valid & ready in the same cycle; this block holds no data.
//   - Reset: state IDLE, grant_idx=0, last=N-1 (requester 0 wins first), burst cnt=0, idle cnt=0;
//     all in_ready=0, out_valid=0, out_data=0, grant_valid=0. Reset mid-byte drops the lock.
//   - IDLE: out_valid=0, out_data=0, in_ready=0. If any in_valid, pick the first set bit scanning
//     last+1, last+2, ... mod N; next cycle: LOCKED, grant_idx=pick, cnt=0, idle=0.
//     Arbitration latency: exactly 1 cycle from IDLE; no transfer in the deciding cycle.
//   - LOCKED (g=grant_idx): out_valid=in_valid[g], out_data=in_data[g], in_ready[g]=out_ready,
//     in_ready[others]=0, grant_valid=1. All combinational; zero-latency pass-through.
//   - On transfer in LOCKED: cnt++; if out_data==TERM or cnt+1==MAX_BURST -> IDLE, last=g.
//     TERM and MAX_BURST coinciding -> single release.
//   - Idle counter: in LOCKED, in_valid[g]=0 -> idle++, else idle=0. idle reaching TIMEOUT-1 while
//     in_valid[g]=0 -> IDLE, last=g (release after TIMEOUT silent cycles). Counter sized for TIMEOUT.
//   - out_ready=0 with in_valid[g]=1 is backpressure, not silence: no timeout, lock held.
//   - After release, IDLE lasts >=1 cycle (no back-to-back regrant in the release cycle).
//   - Requester dropping in_valid without transfer is allowed; no byte is emitted or lost.
//   - Non-granted in_valid may change freely; it has no effect until next IDLE scan.
//   - grant_idx holds its value in IDLE (last holder); grant_valid=0 in IDLE.
// TESTING
//   1 Reset, N=2, both in_valid=1 -> cycle 1 IDLE, cycle 2 grant_idx=0, req0 bytes pass in order.
//   2 req0 sends "AB\n" (41,42,0A), req1 streams 'x' -> out: 41,42,0A then 1 idle cycle then 'x'..;
//     no 'x' inside req0 line; next contention grants req0 only after req1 releases.
//   3 req1 streams 70 bytes, no TERM, MAX_BURST=64 -> release after byte 64, req0 (waiting) granted.
//   4 req0 granted, sends 41 then drops in_valid for TIMEOUT cycles -> release at TIMEOUT, req1
//     granted; with TIMEOUT-1 silent cycles then valid -> lock kept.
//   5 out_ready=0 for 5000 cycles mid-line -> lock held, data stable, no timeout, no loss.
//   6 Assert rst while LOCKED mid-line -> next cycle all outputs at reset values, req0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte stream sink (uart_tx) between N requesters.
// A grant is line-locked until TERM, MAX_BURST bytes, or TIMEOUT silent cycles.
module uart_tx_arbiter #(
  parameter int unsigned N         = 2,
  parameter logic [7:0]  TERM      = 8'h0A,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [8*N-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned GW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic          pick_found;
  logic          g_valid;
  logic [7:0]    g_data;
  logic [7:0]    data_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_arr[i] = in_data[8*i +: 8];
  end

  assign g_valid   = in_valid[grant_q];
  assign g_data    = data_arr[grant_q];
  assign grant_idx = grant_q;

  // Scan starts one past the last holder, so the previous owner ranks lowest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick       = last_q;
    cand       = last_q;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = GW'((32'(last_q) + k) % N);
      if (!pick_found && in_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    out_valid   = 1'b0;
    out_data    = 8'h00;
    in_ready    = '0;
    grant_valid = 1'b0;
    if (state_q == S_LOCKED) begin
      grant_valid       = 1'b1;
      out_valid         = g_valid;
      out_data          = g_data;
      in_ready[grant_q] = out_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_LOCKED;
          grant_d = pick;
          cnt_d   = '0;
          idle_d  = '0;
        end
      end
      S_LOCKED: begin
        if (g_valid) begin
          // Backpressure with data pending is not silence: the idle count clears.
          idle_d = '0;
          if (out_ready) begin
            cnt_d = cnt_q + 1'b1;
            if (g_data == TERM || cnt_q == BURST_LAST) begin
              state_d = S_IDLE;
              last_d  = grant_q;
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N - 1);
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: byte sources feed queues, a monitor pops
// expected {holder, byte, release} entries on every output transfer.
module tb_uart_tx_arbiter;

  localparam int N         = 2;
  localparam int MAX_BURST = 64;
  localparam int TIMEOUT   = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         in_valid;
  logic [8*N-1:0]       in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_ready;
  logic                 grant_valid;
  logic [$clog2(N)-1:0] grant_idx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N(N), .TERM(8'h0A), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         rel;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_push(input int idx, input logic [7:0] d, input bit rel);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_xfer(input string name, input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(out_valid && out_ready) && c < budget);
    check(name, out_valid && out_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant_valid"}, grant_valid, 0);
    check({tag, "_grant_idx"}, grant_idx, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  // Source driver: present queue heads, pop after each accepted byte.
  initial begin
    logic [N-1:0] fire;
    in_valid = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (fire[0] === 1'b1 && src0_q.size() != 0) void'(src0_q.pop_front());
      if (fire[1] === 1'b1 && src1_q.size() != 0) void'(src1_q.pop_front());
      in_valid[0]    = (src0_q.size() != 0);
      in_data[7:0]   = (src0_q.size() != 0) ? src0_q[0] : 8'h00;
      in_valid[1]    = (src1_q.size() != 0);
      in_data[15:8]  = (src1_q.size() != 0) ? src1_q[0] : 8'h00;
    end
  end

  // Monitor: compare every output transfer, then the grant state one cycle later.
  initial begin
    bit   pend     = 1'b0;
    bit   pend_rel = 1'b0;
    int   pend_idx = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("post_xfer_grant_valid", grant_valid, !pend_rel);
          if (!pend_rel) check("post_xfer_grant_idx", grant_idx, pend_idx);
          pend = 1'b0;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_byte: got %02h want none (t=%0t)", out_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_grant_idx", grant_idx, e.idx);
            pend     = 1'b1;
            pend_rel = e.rel;
            pend_idx = e.idx;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int c;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Two lines from req0 around one from req1; release order alternates.
    src0_q = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h0A};
    src1_q = '{8'h78, 8'h78, 8'h78, 8'h0A};
    exp_push(0, 8'h41, 0); exp_push(0, 8'h42, 0); exp_push(0, 8'h0A, 1);
    exp_push(1, 8'h78, 0); exp_push(1, 8'h78, 0); exp_push(1, 8'h78, 0);
    exp_push(1, 8'h0A, 1);
    exp_push(0, 8'h43, 0); exp_push(0, 8'h0A, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_idle_grant_valid", grant_valid, 0);
    check("t1_idle_out_valid", out_valid, 0);
    check("t1_idle_in_ready", in_ready, 0);
    @(negedge clk);
    check("t1_grant_valid", grant_valid, 1);
    check("t1_grant_idx", grant_idx, 0);
    check("t1_first_byte", out_data, 8'h41);
    wait_drain("t2_drain", 200);
    repeat (2) @(negedge clk);

    // Burst limit: req1 holds for 64 bytes, waiting req0 slips in, req1 resumes.
    for (int k = 0; k < 70; k++) src1_q.push_back(8'(8'h80 + k));
    src0_q.push_back(8'h55);
    src0_q.push_back(8'h0A);
    for (int k = 0; k < MAX_BURST; k++) exp_push(1, 8'(8'h80 + k), k == MAX_BURST - 1);
    exp_push(0, 8'h55, 0);
    exp_push(0, 8'h0A, 1);
    for (int k = MAX_BURST; k < 70; k++) exp_push(1, 8'(8'h80 + k), 0);
    wait_drain("t3_drain", 300);
    c = 0;
    while (grant_valid && c < TIMEOUT + 20) begin
      @(negedge clk);
      c++;
    end
    check("t3_tail_timeout_release", grant_valid, 0);
    repeat (2) @(negedge clk);

    // Timeout: req0 goes silent after one byte, released after TIMEOUT cycles.
    src0_q.push_back(8'h41);
    src1_q.push_back(8'h62);
    src1_q.push_back(8'h0A);
    exp_push(0, 8'h41, 0);
    exp_push(1, 8'h62, 0);
    exp_push(1, 8'h0A, 1);
    wait_xfer("t4_first_xfer", 20);
    repeat (TIMEOUT) @(negedge clk);
    check("t4_held_grant_valid", grant_valid, 1);
    check("t4_held_grant_idx", grant_idx, 0);
    check("t4_held_out_valid", out_valid, 0);
    @(negedge clk);
    check("t4_released", grant_valid, 0);
    @(negedge clk);
    check("t4_regrant_valid", grant_valid, 1);
    check("t4_regrant_idx", grant_idx, 1);
    wait_drain("t4_drain", 20);
    repeat (2) @(negedge clk);

    // TIMEOUT-1 silent cycles then data: the lock must survive.
    src0_q.push_back(8'h43);
    exp_push(0, 8'h43, 0);
    wait_xfer("t4b_first_xfer", 20);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t4b_held_grant_valid", grant_valid, 1);
    src0_q.push_back(8'h44);
    src0_q.push_back(8'h0A);
    src1_q.push_back(8'h63);
    src1_q.push_back(8'h0A);
    exp_push(0, 8'h44, 0); exp_push(0, 8'h0A, 1);
    exp_push(1, 8'h63, 0); exp_push(1, 8'h0A, 1);
    wait_drain("t4b_drain", 50);
    repeat (2) @(negedge clk);

    // Long backpressure mid-line: lock and data held, no timeout.
    src0_q = '{8'h31, 8'h32, 8'h33, 8'h0A};
    src1_q = '{8'h64, 8'h0A};
    exp_push(0, 8'h31, 0); exp_push(0, 8'h32, 0); exp_push(0, 8'h33, 0);
    exp_push(0, 8'h0A, 1);
    exp_push(1, 8'h64, 0); exp_push(1, 8'h0A, 1);
    wait_xfer("t5_first_xfer", 20);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (!(grant_valid === 1'b1 && grant_idx === 1'b0 && out_valid === 1'b1 &&
            out_data === 8'h32 && in_ready === 2'b00)) bad++;
    end
    check("t5_stall_stable", bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("t5_drain", 50);
    repeat (2) @(negedge clk);

    // Reset while req1 is mid-line: lock dropped, req0 regains priority.
    src1_q = '{8'h71, 8'h72, 8'h0A};
    exp_push(1, 8'h71, 0);
    wait_xfer("t6_first_xfer", 20);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    src0_q = '{8'h51, 8'h0A};
    exp_push(0, 8'h51, 0); exp_push(0, 8'h0A, 1);
    exp_push(1, 8'h72, 0); exp_push(1, 8'h0A, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t6_reset");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    wait_drain("t6_drain", 50);
    repeat (3) @(negedge clk);
    check("sources_empty", src0_q.size() + src1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
